// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types and helpers for the pulse generator
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulse_state_t;

    function automatic int cyc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter_msdsl.sv
// rtl/sat_counter_msdsl.sv - saturating up/down counter with clear and overflow strobe
module sat_counter_msdsl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf_pulse
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Clear beats everything, so a cleared cycle never reports an overflow.
    always_comb begin
        count_d   = count_q;
        ovf_pulse = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q == CNT_MAX) begin
                ovf_pulse = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_gen_msdsl.sv
// rtl/pulse_gen_msdsl.sv - request-to-pulse generator with min high/low times and a replay queue
module pulse_gen_msdsl
    import pulse_gen_pkg::*;
#(
    parameter logic active   = 1'b1,
    parameter int   HIGH_CYC = 4,
    parameter int   LOW_CYC  = 2,
    parameter int   CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             flush,
    input  logic             ovf_clr,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf
);

    localparam int            T_MAX    = cyc_max(HIGH_CYC, LOW_CYC);
    localparam int            TW       = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] T_HIGH   = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] T_LOW    = TW'(LOW_CYC - 1);
    localparam logic          IDLE_LVL = ~active;

    if (HIGH_CYC < 1 || LOW_CYC < 1) begin : g_param_check
        $error("pulse_gen_msdsl: HIGH_CYC and LOW_CYC must both be >= 1");
    end

    pulse_state_t    state_d, state_q;
    logic [TW-1:0]   timer_d, timer_q;
    logic            out_d, out_q;
    logic            busy_d, busy_q;
    logic            ovf_d, ovf_q;

    logic             pend_avail;
    logic             want;
    logic             start;
    logic             pend_inc;
    logic             pend_dec;
    logic             ovf_set;
    logic [CNT_W-1:0] pend_cnt;

    // A same-cycle flush hides the queue, so only a live req can start a pulse then.
    always_comb begin
        pend_avail = (pend_cnt != '0) && !flush;
        want       = req || pend_avail;
        start      = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        out_d      = out_q;

        case (state_q)
            IDLE: begin
                if (want) begin
                    start   = 1'b1;
                    state_d = HIGH;
                    timer_d = T_HIGH;
                    out_d   = active;
                end
            end
            HIGH: begin
                if (timer_q == '0) begin
                    state_d = LOW;
                    timer_d = T_LOW;
                    out_d   = IDLE_LVL;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOW: begin
                if (timer_q == '0) begin
                    if (want) begin
                        start   = 1'b1;
                        state_d = HIGH;
                        timer_d = T_HIGH;
                        out_d   = active;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                out_d   = IDLE_LVL;
            end
        endcase

        busy_d   = (state_d != IDLE);
        pend_inc = req && !start;
        pend_dec = start && !req;

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            out_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    sat_counter_msdsl #(
        .W(CNT_W)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .inc       (pend_inc),
        .dec       (pend_dec),
        .count     (pend_cnt),
        .ovf_pulse (ovf_set)
    );

    assign out     = out_q;
    assign busy    = busy_q;
    assign pending = pend_cnt;
    assign ovf     = ovf_q;

endmodule
